// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit retiring BITS_PER_CYCLE bits per COMP cycle.
// Define IBEX_MULTDIV_ITER_EARLY_OUT_EN for data-dependent early exits (off = fixed latency).
module ibex_multdiv_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_int,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic [2:0]       dbg_state
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 2) ? $clog2(ITER) : 1;
  localparam int PW   = WIDTH + BITS_PER_CYCLE;
  localparam logic [CW-1:0] CNT_INIT = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_COMP  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q;
  logic [WIDTH-1:0]   result_q;

  // Operand decode and magnitude preparation (valid while in PREP)
  logic             is_div, signed_a, signed_b, neg_a, neg_b, b_zero, sign_d;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_div   = op_q[2];
    signed_a = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
    signed_b = is_div ? ~op_q[0] : ~op_q[1];
    neg_a    = signed_a & a_q[WIDTH-1];
    neg_b    = signed_b & b_q[WIDTH-1];
    a_mag    = neg_a ? (~a_q + WIDTH'(1)) : a_q;
    b_mag    = neg_b ? (~b_q + WIDTH'(1)) : b_q;
    b_zero   = (b_q == '0);
    if (!is_div)       sign_d = neg_a ^ neg_b;
    else if (op_q[1])  sign_d = neg_a;
    else               sign_d = (neg_a ^ neg_b) & ~b_zero;
  end

  // Multiply step: prod_q holds {accumulator, remaining multiplier}
  logic [PW-1:0]      mul_pp, mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_pp   = PW'(a_q) * PW'(prod_q[BITS_PER_CYCLE-1:0]);
    mul_sum  = PW'(prod_q[2*WIDTH-1:WIDTH]) + mul_pp;
    mul_next = {mul_sum, prod_q[WIDTH-1:BITS_PER_CYCLE]};
  end

  // Restoring divide: chained compare-subtract, quotient shifts into prod_q low half
  logic [WIDTH:0]   div_r, div_diff;
  logic [WIDTH-1:0] div_q;

  always_comb begin
    div_r    = {1'b0, rem_q};
    div_q    = prod_q[WIDTH-1:0];
    div_diff = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      div_r    = {div_r[WIDTH-1:0], div_q[WIDTH-1]};
      div_q    = {div_q[WIDTH-2:0], 1'b0};
      div_diff = div_r - {1'b0, a_q};
      if (!div_diff[WIDTH]) begin
        div_r    = div_diff;
        div_q[0] = 1'b1;
      end
    end
  end

  logic               comp_last;
  logic [2*WIDTH-1:0] prod_aligned;

`ifdef IBEX_MULTDIV_ITER_EARLY_OUT_EN
  logic [WIDTH-1:0] rest_mask;
  logic             early_mul;

  // cnt_q digits of multiplier remain after this step; an early exit leaves
  // them unshifted, so FIXUP realigns by the same amount.
  always_comb begin
    rest_mask    = (WIDTH'(1) << (cnt_q * BITS_PER_CYCLE)) - WIDTH'(1);
    early_mul    = (op_q == 3'd0) && ((mul_next[WIDTH-1:0] & rest_mask) == '0);
    comp_last    = (cnt_q == '0) || early_mul;
    prod_aligned = prod_q >> (cnt_q * BITS_PER_CYCLE);
  end
`else
  always_comb begin
    comp_last    = (cnt_q == '0);
    prod_aligned = prod_q;
  end
`endif

  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   div_val, div_signed, fix_result;

  always_comb begin
    prod_signed = sign_q ? (~prod_aligned + (2*WIDTH)'(1)) : prod_aligned;
    div_val     = op_q[1] ? rem_q : prod_q[WIDTH-1:0];
    div_signed  = sign_q ? (~div_val + WIDTH'(1)) : div_val;
    if (is_div)                  fix_result = div_signed;
    else if (op_q[1:0] == 2'b00) fix_result = prod_signed[WIDTH-1:0];
    else                         fix_result = prod_signed[2*WIDTH-1:WIDTH];
  end

  // Valid/ready: a request transfers on an edge with req_valid_i && req_ready_o,
  // a response on an edge with resp_valid_o && resp_ready_i; flush_i overrides both.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_DONE);
    busy_o       = (state_q != S_IDLE);
    dbg_state    = state_q;
    case (state_q)
      S_IDLE:  if (req_valid_i) state_d = S_PREP;
`ifdef IBEX_MULTDIV_ITER_EARLY_OUT_EN
      S_PREP:  state_d = (is_div && b_zero) ? S_DONE : S_COMP;
`else
      S_PREP:  state_d = S_COMP;
`endif
      S_COMP:  if (comp_last) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else if (!flush_i) begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          op_q <= op_i;
          a_q  <= op_a_i;
          b_q  <= op_b_i;
        end
        S_PREP: begin
          // a_q is reused as multiplicand or divisor magnitude from here on
          a_q    <= is_div ? b_mag : a_mag;
          prod_q <= {WIDTH'(0), is_div ? a_mag : b_mag};
          rem_q  <= '0;
          sign_q <= sign_d;
          cnt_q  <= CNT_INIT;
`ifdef IBEX_MULTDIV_ITER_EARLY_OUT_EN
          if (is_div && b_zero) result_q <= op_q[1] ? a_q : '1;
`endif
        end
        S_COMP: begin
          if (is_div) begin
            prod_q[WIDTH-1:0] <= div_q;
            rem_q             <= div_r[WIDTH-1:0];
          end else begin
            prod_q <= mul_next;
          end
          if (!comp_last) cnt_q <= cnt_q - CW'(1);
        end
        S_FIXUP: result_q <= fix_result;
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter: WIDTH=32, BITS_PER_CYCLE=2 main instance,
// plus BITS_PER_CYCLE=1 and 4 instances for the latency scaling check.
module tb_ibex_multdiv_iter;

  localparam int W   = 32;
  localparam int LAT = 18;

  // ---------------- clock / reset ----------------
  logic clk_int = 1'b0;
  logic rst_ni  = 1'b0;
  always #5 clk_int = ~clk_int;

  // ---------------- main DUT (BITS_PER_CYCLE=2) ----------------
  logic         flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         req_ready, resp_valid, busy;
  logic [W-1:0] result;
  logic [2:0]   dbg_state;

  ibex_multdiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut (
    .clk_int(clk_int), .rst_ni(rst_ni), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .op_i(op),
    .op_a_i(op_a), .op_b_i(op_b), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .result_o(result), .busy_o(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- side DUTs (BITS_PER_CYCLE=1 and 4) ----------------
  logic         flush_x = 1'b0, req_valid_x = 1'b0, resp_ready_x = 1'b0;
  logic [2:0]   op_x = '0;
  logic [W-1:0] a_x = '0, b_x = '0;
  logic         r1_req_ready, r1_resp_valid, r1_busy;
  logic         r4_req_ready, r4_resp_valid, r4_busy;
  logic [W-1:0] r1_result, r4_result;
  logic [2:0]   r1_state, r4_state;

  ibex_multdiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut_b1 (
    .clk_int(clk_int), .rst_ni(rst_ni), .flush_i(flush_x),
    .req_valid_i(req_valid_x), .req_ready_o(r1_req_ready), .op_i(op_x),
    .op_a_i(a_x), .op_b_i(b_x), .resp_valid_o(r1_resp_valid),
    .resp_ready_i(resp_ready_x), .result_o(r1_result), .busy_o(r1_busy),
    .dbg_state(r1_state)
  );

  ibex_multdiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut_b4 (
    .clk_int(clk_int), .rst_ni(rst_ni), .flush_i(flush_x),
    .req_valid_i(req_valid_x), .req_ready_o(r4_req_ready), .op_i(op_x),
    .op_a_i(a_x), .op_b_i(b_x), .resp_valid_o(r4_resp_valid),
    .resp_ready_i(resp_ready_x), .result_o(r4_result), .busy_o(r4_busy),
    .dbg_state(r4_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference RV32M semantics from 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f_op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] as_, au, bs, bu, p;
    logic [31:0] r;
    as_ = {{32{a[31]}}, a};
    au  = {32'b0, a};
    bs  = {{32{b[31]}}, b};
    bu  = {32'b0, b};
    p   = '0;
    r   = '0;
    case (f_op)
      3'd0: begin p = as_ * bs; r = p[31:0];  end
      3'd1: begin p = as_ * bs; r = p[63:32]; end
      3'd2: begin p = as_ * bu; r = p[63:32]; end
      3'd3: begin p = au * bu;  r = p[63:32]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_req(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] exp);
    check_val("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    op        = f_op;
    op_a      = a;
    op_b      = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk_int); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int  edges;
    bit  seen;
    logic [W-1:0] e;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk_int); #1;
      edges++;
      if (resp_valid) seen = 1'b1;
    end
    check_val({tag, "_lat"}, edges, exp_lat);
    check_val({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, "_result"}, result, e);
    end
  endtask

  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk_int); #1;
    resp_ready = 1'b0;
    check_val({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f_op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    send_req(f_op, a, b, 1'b1, exp);
    wait_valid(tag, LAT);
    release_resp(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b, held;
    int          nvalid, lat1, lat4;
    logic [31:0] res1, res4;

    #1;
    check_val("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_result", result, 32'd0);
    repeat (2) @(posedge clk_int);
    #1 rst_ni = 1'b1;
    @(posedge clk_int); #1;

    // Directed corner cases
    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_5/0", 3'd6, 32'd5, 32'd0, 32'd5);
    run_op("div_-5/0", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_-5/0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_op("remu_5/0", 3'd7, 32'd5, 32'd0, 32'd5);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r_a = $urandom_range(0, 40);
        1:       r_a = 32'd0 - $urandom_range(0, 40);
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       r_b = 32'd0;
        1:       r_b = $urandom_range(1, 15);
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op("rand", r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
    end

    // Backpressure: result held and no acceptance while resp_ready is low
    send_req(3'd0, 32'd3, 32'd5, 1'b1, 32'd15);
    wait_valid("bp", LAT);
    held      = result;
    req_valid = 1'b1;
    op        = 3'd5;
    op_a      = 32'd9;
    op_b      = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_int); #1;
      check_val("bp_result", result, 32'd15);
      check_val("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check_val("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    release_resp("bp");

    // Flush in COMP cycle 5: request dropped
    send_req(3'd4, 32'd100, 32'd7, 1'b0, 32'd0);
    repeat (5) begin @(posedge clk_int); #1; end
    check_val("fl_in_comp", {29'b0, dbg_state}, 32'd2);
    flush = 1'b1;
    @(posedge clk_int); #1;
    flush = 1'b0;
    check_val("fl_busy", {31'b0, busy}, 32'd0);
    check_val("fl_req_ready", {31'b0, req_ready}, 32'd1);
    // Flush together with a request: acceptance suppressed
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk_int); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    check_val("fl_acc_busy", {31'b0, busy}, 32'd0);
    nvalid = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_int); #1;
      if (resp_valid) nvalid++;
    end
    check_val("fl_no_resp", nvalid, 32'd0);
    run_op("fl_after", 3'd4, 32'd100, 32'd7, 32'd14);

    // Asynchronous reset mid-COMP
    send_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    repeat (6) begin @(posedge clk_int); #1; end
    #2 rst_ni = 1'b0;
    #1;
    check_val("arst_req_ready", {31'b0, req_ready}, 32'd1);
    check_val("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("arst_busy", {31'b0, busy}, 32'd0);
    check_val("arst_result", result, 32'd0);
    @(posedge clk_int); #1;
    rst_ni = 1'b1;
    @(posedge clk_int); #1;
    run_op("arst_after", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

    // Latency scaling with BITS_PER_CYCLE = 1 and 4
    req_valid_x  = 1'b1;
    op_x         = 3'd0;
    a_x          = 32'd7;
    b_x          = 32'hFFFF_FFFD;
    resp_ready_x = 1'b1;
    @(posedge clk_int); #1;
    req_valid_x = 1'b0;
    lat1 = 0;
    lat4 = 0;
    res1 = '0;
    res4 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_int); #1;
      if (r1_resp_valid && lat1 == 0) begin lat1 = i; res1 = r1_result; end
      if (r4_resp_valid && lat4 == 0) begin lat4 = i; res4 = r4_result; end
    end
    check_val("b1_lat", lat1, 32'd34);
    check_val("b1_result", res1, 32'hFFFF_FFEB);
    check_val("b4_lat", lat4, 32'd10);
    check_val("b4_result", res4, 32'hFFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
